// File: rtl/stack_seq_pkg.sv
`default_nettype none
// ============================================================================
// stack_seq_pkg : shared types and constants for the stack sequencer
// Rev 1.0
// ============================================================================
package stack_seq_pkg;

  localparam int PC_W   = 32;
  localparam int DATA_W = 16;
  localparam int FLAG_W = 3;

  localparam logic [PC_W-1:0] DEF_INT_VECTOR = 32'h0000_0010;

  // Stack beats per transfer: PC halves, plus the flag word for INT/RTI.
  localparam int CALL_BEATS = 2;
  localparam int RET_BEATS  = 2;
  localparam int INT_BEATS  = 3;
  localparam int RTI_BEATS  = 3;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_PUSH_FL = 4'd1,
    ST_PUSH_HI = 4'd2,
    ST_PUSH_LO = 4'd3,
    ST_POP_LO  = 4'd4,
    ST_POP_HI  = 4'd5,
    ST_POP_FL  = 4'd6,
    ST_CAP_HI  = 4'd7,
    ST_CAP_FL  = 4'd8,
    ST_JUMP    = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    OP_CALL = 2'd0,
    OP_RET  = 2'd1,
    OP_INT  = 2'd2,
    OP_RTI  = 2'd3
  } op_t;

endpackage
`default_nettype wire

// File: rtl/stack_seq_fsm.sv
`default_nettype none
// ============================================================================
// stack_seq_fsm : beat sequencer state, request arbitration, pending interrupt
// Rev 1.0   (interrupt/RTI support under STACK_SEQ_INT_EN)
// ============================================================================
module stack_seq_fsm
  import stack_seq_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_call_req,
  input  logic   i_ret_req,
  input  logic   i_rti_req,
  input  logic   i_int_req,
  output logic   o_accept,
  output state_t o_state,
  output op_t    o_op
);

  state_t r_state;
  op_t    r_op;
  op_t    w_acc_op;
  logic   w_accept;
  logic   w_int;
  logic   w_rti;
  logic   w_ret;

`ifdef STACK_SEQ_INT_EN
  logic r_pend;
  assign w_int = i_int_req | r_pend;
  assign w_rti = i_rti_req;
  assign w_ret = i_ret_req;
`else
  logic w_unused;
  assign w_int    = 1'b0;
  assign w_rti    = 1'b0;
  assign w_ret    = i_ret_req | i_rti_req;
  assign w_unused = i_int_req;
`endif

  always_comb begin
    w_accept = 1'b0;
    w_acc_op = OP_CALL;
    if (r_state == ST_IDLE && !reset) begin
      if (w_int) begin
        w_accept = 1'b1;
        w_acc_op = OP_INT;
      end else if (w_rti) begin
        w_accept = 1'b1;
        w_acc_op = OP_RTI;
      end else if (w_ret) begin
        w_accept = 1'b1;
        w_acc_op = OP_RET;
      end else if (i_call_req) begin
        w_accept = 1'b1;
        w_acc_op = OP_CALL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_CALL;
`ifdef STACK_SEQ_INT_EN
      r_pend  <= 1'b0;
`endif
    end else begin
`ifdef STACK_SEQ_INT_EN
      // Interrupts arriving mid-sequence wait here for the next IDLE cycle.
      if (w_accept && w_acc_op == OP_INT)
        r_pend <= 1'b0;
      else if (i_int_req && r_state != ST_IDLE)
        r_pend <= 1'b1;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op <= w_acc_op;
            case (w_acc_op)
              OP_CALL: r_state <= ST_PUSH_HI;
`ifdef STACK_SEQ_INT_EN
              OP_INT:  r_state <= ST_PUSH_FL;
`endif
              default: r_state <= ST_POP_LO;
            endcase
          end
        end
`ifdef STACK_SEQ_INT_EN
        ST_PUSH_FL: r_state <= ST_PUSH_HI;
        ST_POP_HI:  r_state <= (r_op == OP_RTI) ? ST_POP_FL : ST_CAP_HI;
        ST_POP_FL:  r_state <= ST_CAP_FL;
        ST_CAP_FL:  r_state <= ST_JUMP;
`else
        ST_POP_HI:  r_state <= ST_CAP_HI;
`endif
        ST_PUSH_HI: r_state <= ST_PUSH_LO;
        ST_PUSH_LO: r_state <= ST_JUMP;
        ST_POP_LO:  r_state <= ST_POP_HI;
        ST_CAP_HI:  r_state <= ST_JUMP;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_accept = w_accept;
  assign o_state  = r_state;
  assign o_op     = r_op;

endmodule
`default_nettype wire

// File: rtl/stack_sequencer.sv
`default_nettype none
// ============================================================================
// stack_sequencer : CALL/RET/INT/RTI stack beat controller with pipeline stall
// Rev 1.0   (interrupt/RTI support under STACK_SEQ_INT_EN)
// ============================================================================
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] INT_VECTOR = DEF_INT_VECTOR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic              rti_req,
  input  logic              int_req,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [PC_W-1:0]   target_pc,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [DATA_W-1:0] pop_data,
  output logic              mem_push,
  output logic              mem_pop,
  output logic [DATA_W-1:0] push_data,
  output logic              stall,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_out,
  output logic              flags_restore_en,
  output logic [FLAG_W-1:0] flags_out,
  output logic              busy
);

  logic   w_accept;
  state_t w_state;
  op_t    w_op;

  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_target;
  logic [DATA_W-1:0] r_lo;
  logic [PC_W-1:0]   r_pc_out;

  stack_seq_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .i_call_req (call_req),
    .i_ret_req  (ret_req),
    .i_rti_req  (rti_req),
    .i_int_req  (int_req),
    .o_accept   (w_accept),
    .o_state    (w_state),
    .o_op       (w_op)
  );

`ifdef STACK_SEQ_INT_EN
  logic [FLAG_W-1:0] r_flags;
  logic [DATA_W-1:0] r_hi;
  logic [FLAG_W-1:0] r_flags_out;

  assign mem_push = (w_state == ST_PUSH_FL) | (w_state == ST_PUSH_HI) |
                    (w_state == ST_PUSH_LO);
  assign mem_pop  = (w_state == ST_POP_LO) | (w_state == ST_POP_HI) |
                    (w_state == ST_POP_FL);
  assign flags_restore_en = (w_state == ST_JUMP) && (w_op == OP_RTI);
  assign flags_out        = r_flags_out;
`else
  logic w_unused;
  assign mem_push = (w_state == ST_PUSH_HI) | (w_state == ST_PUSH_LO);
  assign mem_pop  = (w_state == ST_POP_LO) | (w_state == ST_POP_HI);
  assign flags_restore_en = 1'b0;
  assign flags_out        = '0;
  assign w_unused         = ^flags_in;
`endif

  assign busy    = (w_state != ST_IDLE);
  assign stall   = busy | w_accept;
  assign pc_load = (w_state == ST_JUMP);
  assign pc_out  = r_pc_out;

  always_comb begin
    push_data = '0;
    case (w_state)
`ifdef STACK_SEQ_INT_EN
      ST_PUSH_FL: push_data = {{(DATA_W-FLAG_W){1'b0}}, r_flags};
`endif
      ST_PUSH_HI: push_data = r_pc[PC_W-1:DATA_W];
      ST_PUSH_LO: push_data = r_pc[DATA_W-1:0];
      default:    ;
    endcase
  end

  // pc_out/flags_out are loaded in the beat before JUMP so they are valid with pc_load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= '0;
      r_target    <= '0;
      r_lo        <= '0;
      r_pc_out    <= '0;
`ifdef STACK_SEQ_INT_EN
      r_flags     <= '0;
      r_hi        <= '0;
      r_flags_out <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_pc     <= pc_in;
        r_target <= target_pc;
`ifdef STACK_SEQ_INT_EN
        r_flags  <= flags_in;
`endif
      end
      case (w_state)
        ST_PUSH_LO: r_pc_out <= (w_op == OP_INT) ? INT_VECTOR : r_target;
        ST_POP_HI:  r_lo     <= pop_data;
        ST_CAP_HI:  r_pc_out <= {pop_data, r_lo};
`ifdef STACK_SEQ_INT_EN
        ST_POP_FL:  r_hi     <= pop_data;
        ST_CAP_FL: begin
          r_pc_out    <= {r_hi, r_lo};
          r_flags_out <= pop_data[FLAG_W-1:0];
        end
`endif
        default:    ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// ============================================================================
// tb_stack_sequencer : directed cycle-by-cycle checks of stack_sequencer
// Rev 1.0
// ============================================================================
module tb_stack_sequencer;
  import stack_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        call_req, ret_req, rti_req, int_req;
  logic [31:0] pc_in, target_pc;
  logic [2:0]  flags_in;
  logic [15:0] pop_data;
  logic        mem_push, mem_pop, stall, pc_load, flags_restore_en, busy;
  logic [15:0] push_data;
  logic [31:0] pc_out;
  logic [2:0]  flags_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stack_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .call_req         (call_req),
    .ret_req          (ret_req),
    .rti_req          (rti_req),
    .int_req          (int_req),
    .pc_in            (pc_in),
    .target_pc        (target_pc),
    .flags_in         (flags_in),
    .pop_data         (pop_data),
    .mem_push         (mem_push),
    .mem_pop          (mem_pop),
    .push_data        (push_data),
    .stall            (stall),
    .pc_load          (pc_load),
    .pc_out           (pc_out),
    .flags_restore_en (flags_restore_en),
    .flags_out        (flags_out),
    .busy             (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctl = {stall, busy, mem_push, mem_pop, pc_load, flags_restore_en}
  task automatic cyc(input string tag, input logic [5:0] ctl, input logic [15:0] pd);
    #1;
    check({tag, " ctl"}, {26'd0, stall, busy, mem_push, mem_pop, pc_load, flags_restore_en},
          {26'd0, ctl});
    check({tag, " pdata"}, {16'd0, push_data}, {16'd0, pd});
    tick();
  endtask

  task automatic clr_reqs();
    call_req = 1'b0;
    ret_req  = 1'b0;
    rti_req  = 1'b0;
    int_req  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clr_reqs();
    pc_in     = '0;
    target_pc = '0;
    flags_in  = '0;
    pop_data  = '0;
    repeat (2) tick();
    reset = 1'b0;

    cyc("reset", 6'b000000, 16'h0);
    check("reset pc_out", pc_out, 32'h0);
    check("reset flags_out", {29'd0, flags_out}, 32'h0);

    // CALL; a RET in cycle 1 must be ignored and pc_in changes must not leak in
    call_req = 1'b1; pc_in = 32'h0001_0020; target_pc = 32'h0000_0400;
    cyc("call c0", 6'b100000, 16'h0);
    clr_reqs(); ret_req = 1'b1; pc_in = 32'hDEAD_BEEF; target_pc = 32'h0;
    cyc("call c1", 6'b111000, 16'h0001);
    ret_req = 1'b0;
    cyc("call c2", 6'b111000, 16'h0020);
    check("call c3 pc_out", pc_out, 32'h0000_0400);
    cyc("call c3", 6'b110010, 16'h0);
    cyc("call c4", 6'b000000, 16'h0);
    check("call hold pc_out", pc_out, 32'h0000_0400);

    // RET
    ret_req = 1'b1;
    cyc("ret c0", 6'b100000, 16'h0);
    clr_reqs();
    cyc("ret c1", 6'b110100, 16'h0);
    pop_data = 16'h0020;
    cyc("ret c2", 6'b110100, 16'h0);
    pop_data = 16'h0001;
    cyc("ret c3", 6'b110000, 16'h0);
    pop_data = 16'h0;
    check("ret c4 pc_out", pc_out, 32'h0001_0020);
    cyc("ret c4", 6'b110010, 16'h0);
    cyc("ret c5", 6'b000000, 16'h0);

    // RET beats CALL when both arrive together
    ret_req = 1'b1; call_req = 1'b1; target_pc = 32'h0000_0777;
    cyc("retcall c0", 6'b100000, 16'h0);
    clr_reqs();
    cyc("retcall c1", 6'b110100, 16'h0);
    pop_data = 16'h5678;
    cyc("retcall c2", 6'b110100, 16'h0);
    pop_data = 16'h0009;
    cyc("retcall c3", 6'b110000, 16'h0);
    check("retcall pc_out", pc_out, 32'h0009_5678);
    cyc("retcall c4", 6'b110010, 16'h0);
    cyc("retcall c5", 6'b000000, 16'h0);

`ifdef STACK_SEQ_INT_EN
    // INT entry
    int_req = 1'b1; flags_in = 3'b101; pc_in = 32'h0001_0020;
    cyc("int c0", 6'b100000, 16'h0);
    clr_reqs(); flags_in = 3'b000;
    cyc("int c1", 6'b111000, 16'h0005);
    cyc("int c2", 6'b111000, 16'h0001);
    cyc("int c3", 6'b111000, 16'h0020);
    check("int pc_out", pc_out, 32'h0000_0010);
    cyc("int c4", 6'b110010, 16'h0);
    cyc("int c5", 6'b000000, 16'h0);

    // RTI
    rti_req = 1'b1;
    cyc("rti c0", 6'b100000, 16'h0);
    clr_reqs();
    cyc("rti c1", 6'b110100, 16'h0);
    pop_data = 16'h0020;
    cyc("rti c2", 6'b110100, 16'h0);
    pop_data = 16'h0001;
    cyc("rti c3", 6'b110100, 16'h0);
    pop_data = 16'h0005;
    cyc("rti c4", 6'b110000, 16'h0);
    pop_data = 16'h0;
    check("rti pc_out", pc_out, 32'h0001_0020);
    check("rti flags_out", {29'd0, flags_out}, {29'd0, 3'b101});
    cyc("rti c5", 6'b110011, 16'h0);
    cyc("rti c6", 6'b000000, 16'h0);

    // interrupt during CALL becomes pending and follows with no idle gap
    call_req = 1'b1; pc_in = 32'h0002_0030; target_pc = 32'h0000_0500;
    cyc("b2b c0", 6'b100000, 16'h0);
    clr_reqs(); int_req = 1'b1;
    cyc("b2b c1", 6'b111000, 16'h0002);
    int_req = 1'b0;
    cyc("b2b c2", 6'b111000, 16'h0030);
    check("b2b call pc_out", pc_out, 32'h0000_0500);
    cyc("b2b c3", 6'b110010, 16'h0);
    pc_in = 32'h0003_0040; flags_in = 3'b011;
    cyc("b2b c4", 6'b100000, 16'h0);
    pc_in = 32'h0; flags_in = 3'b000;
    cyc("b2b c5", 6'b111000, 16'h0003);
    cyc("b2b c6", 6'b111000, 16'h0003);
    cyc("b2b c7", 6'b111000, 16'h0040);
    check("b2b int pc_out", pc_out, 32'h0000_0010);
    cyc("b2b c8", 6'b110010, 16'h0);
    cyc("b2b c9", 6'b000000, 16'h0);

    // INT beats CALL, CALL is dropped
    int_req = 1'b1; call_req = 1'b1; flags_in = 3'b001;
    pc_in = 32'h0004_0050; target_pc = 32'h0000_0600;
    cyc("intcall c0", 6'b100000, 16'h0);
    clr_reqs();
    cyc("intcall c1", 6'b111000, 16'h0001);
    cyc("intcall c2", 6'b111000, 16'h0004);
    cyc("intcall c3", 6'b111000, 16'h0050);
    check("intcall pc_out", pc_out, 32'h0000_0010);
    cyc("intcall c4", 6'b110010, 16'h0);
    cyc("intcall c5", 6'b000000, 16'h0);
`else
    // int_req has no effect
    int_req = 1'b1;
    cyc("intoff c0", 6'b000000, 16'h0);
    int_req = 1'b0;
    cyc("intoff c1", 6'b000000, 16'h0);

    // int_req alongside CALL: plain CALL runs
    int_req = 1'b1; call_req = 1'b1; pc_in = 32'h0004_0050; target_pc = 32'h0000_0600;
    cyc("intcall c0", 6'b100000, 16'h0);
    clr_reqs();
    cyc("intcall c1", 6'b111000, 16'h0004);
    cyc("intcall c2", 6'b111000, 16'h0050);
    check("intcall pc_out", pc_out, 32'h0000_0600);
    cyc("intcall c3", 6'b110010, 16'h0);
    cyc("intcall c4", 6'b000000, 16'h0);

    // RTI behaves as RET: two pops, no flag restore
    rti_req = 1'b1;
    cyc("rtioff c0", 6'b100000, 16'h0);
    clr_reqs();
    cyc("rtioff c1", 6'b110100, 16'h0);
    pop_data = 16'h1234;
    cyc("rtioff c2", 6'b110100, 16'h0);
    pop_data = 16'hABCD;
    cyc("rtioff c3", 6'b110000, 16'h0);
    pop_data = 16'h0;
    check("rtioff pc_out", pc_out, 32'hABCD_1234);
    cyc("rtioff c4", 6'b110010, 16'h0);
    cyc("rtioff c5", 6'b000000, 16'h0);
    check("rtioff flags_out", {29'd0, flags_out}, 32'h0);
`endif

    // reset in PUSH_HI: no further beats, no pc_load, outputs cleared
    call_req = 1'b1; pc_in = 32'h0006_0070; target_pc = 32'h0000_0800;
    cyc("rstmid c0", 6'b100000, 16'h0);
    clr_reqs(); reset = 1'b1;
    cyc("rstmid c1", 6'b111000, 16'h0006);
    reset = 1'b0;
    check("rstmid pc_out", pc_out, 32'h0);
    cyc("rstmid c2", 6'b000000, 16'h0);
    cyc("rstmid c3", 6'b000000, 16'h0);
    cyc("rstmid c4", 6'b000000, 16'h0);
    check("rstmid pc_out hold", pc_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack_sequencer.md
# stack_sequencer

Multi-cycle controller that sequences the stack-push/pop path through the execute and memory stages for CALL, RET, hardware interrupt and RTI. The execute stage drives 16-bit data while the PC is 32 bits, so each control transfer needs several stack beats. This block sequences those beats, stalls the front of the pipeline while they run, then issues a single PC load and, for RTI, a flag restore. It sits beside the execute stage, fed by decode requests, and drives the memory stage push/pop controls.

## Interface
- INT_VECTOR, 32'h0000_0010, PC loaded on interrupt entry
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- call_req / ret_req / rti_req  in  1 each  single-cycle decode requests
- int_req  in  1  external interrupt, sampled every cycle
- pc_in  in  32  return address to save (next sequential PC)
- target_pc  in  32  CALL destination (Rdest, zero-extended)
- flags_in  in  3  current {carry, negative, zero}
- pop_data  in  16  stack read data, valid the cycle after mem_pop
- mem_push / mem_pop  out  1 each  one stack beat per asserted cycle
- push_data  out  16  data for the push beat
- stall  out  1  freeze fetch/decode and bubble execute
- pc_load  out  1  one-cycle pulse, load pc_out
- pc_out  out  32  new PC
- flags_restore_en  out  1  one-cycle pulse, load flags_out into the flag register
- flags_out  out  3  restored flags
- busy  out  1  state != IDLE

## Operation
- States: IDLE, PUSH_FL, PUSH_HI, PUSH_LO, POP_LO, POP_HI, POP_FL, CAP_HI, CAP_FL, JUMP.
- Requests are accepted only in IDLE. Priority: int (including a pending interrupt) > rti > ret > call.
- On acceptance, pc_in, target_pc and flags_in are latched. stall is asserted in the acceptance cycle itself (combinational from the request).
- CALL: PUSH_HI (push pc[31:16]) -> PUSH_LO (push pc[15:0]) -> JUMP (pc_out = latched target).
- INT: PUSH_FL (push {13'b0, flags}) -> PUSH_HI -> PUSH_LO -> JUMP (pc_out = INT_VECTOR).
- RET: POP_LO -> POP_HI (capture low half) -> CAP_HI (capture high half) -> JUMP (pc_out = {hi, lo}).
- RTI: POP_LO -> POP_HI (capture low) -> POP_FL (capture high) -> CAP_FL (capture pop_data[2:0]) -> JUMP, with flags_restore_en asserted alongside pc_load.
- JUMP always returns to IDLE.
- An int_req seen while busy sets a sticky pending bit. The bit clears when the interrupt is accepted in IDLE. Any other request seen while busy is ignored, because decode is stalled.
- mem_push and mem_pop are never asserted together. push_data is 0 when mem_push is low.
- Reset in any state: next cycle is IDLE, the pending bit clears, the beat in flight is dropped, and no pc_load is issued.

## Timing
- Reset values: every output is 0 and pc_out is 32'h0.
- Cycle 0 is the acceptance cycle.
- CALL: beats in cycles 1–2, pc_load in cycle 3, stall high for cycles 0–3.
- INT: beats in cycles 1–3, pc_load in cycle 4.
- RET: pops in cycles 1–2, pc_load in cycle 4.
- RTI: pops in cycles 1–3, pc_load and flags_restore_en in cycle 5.
- stall stays high through the JUMP cycle and is low in the following IDLE cycle unless a new request is accepted.
- A pending interrupt is accepted in the first IDLE cycle, so back-to-back sequences have zero idle gap and stall remains high.
- pc_out and flags_out are registered. They hold their value after the pulse until the next JUMP.

## Configuration
- STACK_SEQ_INT_EN defined: interrupt and RTI support are built in, as described above.
- STACK_SEQ_INT_EN undefined:
  - int_req is ignored and the pending bit is not built.
  - PUSH_FL, POP_FL and CAP_FL are not built.
  - rti_req behaves exactly like ret_req.
  - flags_restore_en is tied to 0.

## Structure
- Shared package stack_seq_pkg holds:
  - the state enum;
  - the beat-count constants;
  - PC_W = 32, DATA_W = 16 and FLAG_W = 3;
  - the default INT_VECTOR.
- The single sub-module is stack_seq_fsm (state register, next-state logic, pending bit). The top level holds the latches and the PC/flag assembly.

## Test plan
- CALL with pc_in = 32'h0001_0020 and target = 32'h0000_0400 -> push 16'h0001 in cycle 1, push 16'h0020 in cycle 2, pc_load with pc_out = 32'h0000_0400 in cycle 3, stall high for cycles 0–3.
- RET with pop_data 16'h0020 then 16'h0001 -> pc_out = 32'h0001_0020 in cycle 4, two mem_pop beats.
- INT with flags = 3'b101 -> pushes 16'h0005, pc_hi, pc_lo; then pc_out = 32'h0000_0010. RTI popping lo, hi, 16'h0005 -> flags_out = 3'b101 and flags_restore_en pulses in cycle 5.
- int_req during cycle 1 of a CALL -> CALL completes; INT is accepted in the next cycle and PUSH_FL follows with no gap.
- Simultaneous int_req and call_req -> INT wins and call is dropped. reset asserted in PUSH_HI -> IDLE on the next cycle, no further push, no pc_load.
- With STACK_SEQ_INT_EN undefined: int_req produces no effect; rti_req produces 2 pops and flags_restore_en stays 0.
